wave_poly: RTL and testbench
============================

Name: wave_poly

Overview:
- Time-multiplexed, parametrised successor to the single-voice oscillator.
- Holds NUM_VOICES phase accumulators and per-voice config in registers. On each sample_tick it sweeps all voices, one per main_clk cycle.
- Per voice: combinable triangle/saw/pulse/noise waveforms, hard sync and ring modulation from the neighbour voice.
- Emits one signed mixed sample per sweep into the downstream filter/DAC path.

Parameters:
NUM_VOICES, 3, voice count (>=2)
FREQ_BITS, 16, frequency word width
PULSEWIDTH_BITS, 12, pulse-width compare width
OUTPUT_BITS, 12, per-voice sample width (<=23)
ACCUMULATOR_BITS, 24, phase accumulator width (>=OUTPUT_BITS+1, >=PULSEWIDTH_BITS)
VIDX_BITS, $clog2(NUM_VOICES), voice index width
MIX_BITS, OUTPUT_BITS+$clog2(NUM_VOICES)+1, mixed output width

Ports:
main_clk  in  1  sole clock
reset  in  1  asynchronous, active-high
sample_tick  in  1  one-cycle strobe that starts a sweep
cfg_we  in  1  config write strobe
cfg_voice  in  VIDX_BITS  target voice
cfg_freq  in  FREQ_BITS  tone frequency
cfg_pw  in  PULSEWIDTH_BITS  pulse width
cfg_wave  in  4  [0]tri [1]saw [2]pulse [3]noise
cfg_sync  in  1  hard-sync enable
cfg_ringmod  in  1  ring-mod enable
cfg_test  in  1  hold accumulator/LFSR in reset
mix_out  out  signed MIX_BITS  mixed sample
mix_valid  out  1  one-cycle pulse, mix_out updated
busy  out  1  sweep in progress
voice_msb  out  NUM_VOICES  accumulator MSB per voice

Behaviour:
- Reset (async): all accumulators 0, LFSRs = 23'h7FFFF8, all config 0, mix_out 0, mix_valid 0, busy 0, voice_msb 0, FSM IDLE.
- FSM IDLE -> SWEEP on sample_tick; sample_tick in SWEEP/DONE is ignored.
- SWEEP processes voice idx = 0..N-1, one per cycle.
- SWEEP -> DONE after idx N-1. DONE drives mix_valid=1 for one cycle, then returns to IDLE.
- Latency: tick at cycle T -> mix_valid at T+N+1. busy=1 from T+1 through T+N+1.
- Per-voice update:
  - acc <= acc + zero-extended freq, modulo 2^ACCUMULATOR_BITS.
  - cfg_test=1: acc <= 0 and LFSR <= seed.
  - Hard sync: if sync=1 and the source voice (idx-1 mod N) had a rising MSB on its most recent update, acc <= 0 instead of advancing. For voice 0 the source update belongs to the previous sweep. The rise flag is stored per voice.
- LFSR: 23-bit, shift left, feedback bit22^bit17. Steps when acc bit (ACCUMULATOR_BITS-5) rises across the update.
- Waveforms are computed from the post-update acc:
  - saw = acc[top OUTPUT_BITS].
  - tri = acc[ACCUMULATOR_BITS-2 -: OUTPUT_BITS], bitwise inverted when t=1. t = acc MSB, XORed with source voice MSB when ringmod=1.
  - pulse = all-ones if acc[top PULSEWIDTH_BITS] < pw, else 0.
  - noise = lfsr[22 -: OUTPUT_BITS].
- Selected waveforms are bitwise ANDed. The unsigned result u gives signed sample u ^ (1<<(OUTPUT_BITS-1)). cfg_wave=0 -> sample 0.
- Mix: signed, sign-extended accumulation across the sweep, cleared at sweep start. No overflow possible at the chosen MIX_BITS. mix_out loads in DONE and holds until the next DONE.
- cfg_we: write applies next cycle in any state. A write to the voice processed in the same cycle does not affect that cycle. Write with cfg_voice >= NUM_VOICES is ignored.
- Reset mid-sweep: state cleared immediately, no mix_valid.

Decomposition:
- Package wave_pkg: waveform select bit indices, LFSR width/seed/taps, FSM state enum.
- Sub-module wave_voice_core (combinational): acc, LFSR, config, source MSB -> signed voice sample and next acc/LFSR.

Test Plan:
- Reset; voice0 freq=0x1000 saw, others off; one tick -> mix_valid exactly 4 cycles later, mix_out = -2047. voice_msb = 0.
- Voice0 pulse, pw=0x800, freq=0x8000, ticks repeated -> mix_out = +2047 on ticks 1..255, -2048 on tick 256.
- Voice0 freq=0x800000 -> voice_msb[0] toggles 1,0,1 on successive sweeps; acc wraps to 0.
- Voice0 freq=0x400000; voice1 freq=0x010000 with sync -> voice1 acc cleared on sweep 2 (voice0 acc=0x800000). Otherwise voice1 acc increments by 0x010000 per sweep.
- Voice0 noise with cfg_test=1 -> mix_out constant 0xFFF^0x800 sign-extended (+2047). After clearing test, value changes once bit19 rises.
- Second sample_tick 2 cycles after the first -> single mix_valid. Assert reset mid-sweep -> no mix_valid, all outputs 0.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared definitions for the polyphonic oscillator: waveform select bits, noise LFSR, sweep FSM states.
// Latency: none (package only).
// Backpressure: none (package only).
package wave_pkg;

  // Bit positions inside the 4-bit waveform select word
  localparam int WAVE_TRI   = 0;
  localparam int WAVE_SAW   = 1;
  localparam int WAVE_PULSE = 2;
  localparam int WAVE_NOISE = 3;

  // Noise generator: 23-bit shift-left register, feedback from bits 22 and 17
  localparam int                   LFSR_BITS  = 23;
  localparam logic [LFSR_BITS-1:0] LFSR_SEED  = 23'h7FFFF8;
  localparam int                   LFSR_TAP_A = 22;
  localparam int                   LFSR_TAP_B = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One shift of the noise register
  function automatic logic [LFSR_BITS-1:0] lfsr_step(input logic [LFSR_BITS-1:0] s);
    return {s[LFSR_BITS-2:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
  endfunction

endpackage

// File: rtl/wave_voice_core.sv
// Single-voice datapath: advances phase/noise state and forms the signed voice sample.
// Latency: purely combinational; the caller registers acc_next/lfsr_next.
// Backpressure: none; evaluated whenever the sweep presents a voice.
module wave_voice_core
  import wave_pkg::*;
#(
  parameter int FREQ_BITS        = 16,
  parameter int PULSEWIDTH_BITS  = 12,
  parameter int OUTPUT_BITS      = 12,
  parameter int ACCUMULATOR_BITS = 24
) (
  input  logic [ACCUMULATOR_BITS-1:0]   acc,
  input  logic [LFSR_BITS-1:0]          lfsr,
  input  logic [FREQ_BITS-1:0]          freq,
  input  logic [PULSEWIDTH_BITS-1:0]    pw,
  input  logic [3:0]                    wave,
  input  logic                          sync,
  input  logic                          ringmod,
  input  logic                          test,
  input  logic                          src_msb,
  input  logic                          src_rise,
  output logic [ACCUMULATOR_BITS-1:0]   acc_next,
  output logic [LFSR_BITS-1:0]          lfsr_next,
  output logic                          msb_rise,
  output logic signed [OUTPUT_BITS-1:0] sample
);

  localparam int MSB       = ACCUMULATOR_BITS - 1;
  localparam int NOISE_BIT = ACCUMULATOR_BITS - 5;
  localparam logic [OUTPUT_BITS-1:0] SIGN_FLIP = {1'b1, {(OUTPUT_BITS-1){1'b0}}};

  logic                   t;
  logic [OUTPUT_BITS-1:0] tri_w;
  logic [OUTPUT_BITS-1:0] saw_w;
  logic [OUTPUT_BITS-1:0] pulse_w;
  logic [OUTPUT_BITS-1:0] noise_w;
  logic [OUTPUT_BITS-1:0] u;

  // Phase and noise update: test mode parks both, hard sync restarts the phase
  always_comb begin
    acc_next  = acc + ACCUMULATOR_BITS'(freq);
    lfsr_next = lfsr;
    if (test) begin
      acc_next  = '0;
      lfsr_next = LFSR_SEED;
    end else begin
      if (sync && src_rise) begin
        acc_next = '0;
      end
      if (!acc[NOISE_BIT] && acc_next[NOISE_BIT]) begin
        lfsr_next = lfsr_step(lfsr);
      end
    end
    msb_rise = !acc[MSB] && acc_next[MSB];
  end

  // Waveform generation from the updated phase; selected shapes are ANDed together
  always_comb begin
    t       = acc_next[MSB] ^ (ringmod & src_msb);
    tri_w   = acc_next[ACCUMULATOR_BITS-2 -: OUTPUT_BITS] ^ {OUTPUT_BITS{t}};
    saw_w   = acc_next[MSB -: OUTPUT_BITS];
    pulse_w = (acc_next[MSB -: PULSEWIDTH_BITS] < pw) ? '1 : '0;
    noise_w = lfsr_next[LFSR_BITS-1 -: OUTPUT_BITS];
    u       = '1;
    if (wave[WAVE_TRI])   u = u & tri_w;
    if (wave[WAVE_SAW])   u = u & saw_w;
    if (wave[WAVE_PULSE]) u = u & pulse_w;
    if (wave[WAVE_NOISE]) u = u & noise_w;
    // Offset-binary to two's complement; a silent voice contributes exactly zero
    sample = (wave == 4'b0000) ? '0 : $signed(u ^ SIGN_FLIP);
  end

endmodule

// File: rtl/wave_poly.sv
// Time-multiplexed N-voice oscillator: per-tick sweep over all voices, summed into one signed sample.
// Latency: sample_tick at cycle T gives mix_valid at T+NUM_VOICES+1; busy covers T+1..T+NUM_VOICES+1.
// Backpressure: none; ticks arriving while busy are dropped, config writes are accepted every cycle.
module wave_poly
  import wave_pkg::*;
#(
  parameter int NUM_VOICES       = 3,
  parameter int FREQ_BITS        = 16,
  parameter int PULSEWIDTH_BITS  = 12,
  parameter int OUTPUT_BITS      = 12,
  parameter int ACCUMULATOR_BITS = 24,
  parameter int VIDX_BITS        = $clog2(NUM_VOICES),
  parameter int MIX_BITS         = OUTPUT_BITS + $clog2(NUM_VOICES) + 1
) (
  input  logic                        main_clk,
  input  logic                        reset,
  input  logic                        sample_tick,
  input  logic                        cfg_we,
  input  logic [VIDX_BITS-1:0]        cfg_voice,
  input  logic [FREQ_BITS-1:0]        cfg_freq,
  input  logic [PULSEWIDTH_BITS-1:0]  cfg_pw,
  input  logic [3:0]                  cfg_wave,
  input  logic                        cfg_sync,
  input  logic                        cfg_ringmod,
  input  logic                        cfg_test,
  output logic signed [MIX_BITS-1:0]  mix_out,
  output logic                        mix_valid,
  output logic                        busy,
  output logic [NUM_VOICES-1:0]       voice_msb
);

  localparam int MSB = ACCUMULATOR_BITS - 1;
  localparam logic [VIDX_BITS-1:0] LAST_IDX    = VIDX_BITS'(NUM_VOICES - 1);
  localparam logic [VIDX_BITS:0]   VOICE_LIMIT = (VIDX_BITS + 1)'(NUM_VOICES);

  state_t                 state;
  logic [VIDX_BITS-1:0]   idx;
  logic [VIDX_BITS-1:0]   src_idx;
  logic signed [MIX_BITS-1:0] mix_acc;

  // Per-voice running state
  logic [ACCUMULATOR_BITS-1:0] acc_q  [NUM_VOICES];
  logic [LFSR_BITS-1:0]        lfsr_q [NUM_VOICES];
  logic [NUM_VOICES-1:0]       rise_q;

  // Per-voice configuration
  logic [FREQ_BITS-1:0]        freq_q [NUM_VOICES];
  logic [PULSEWIDTH_BITS-1:0]  pw_q   [NUM_VOICES];
  logic [3:0]                  wave_q [NUM_VOICES];
  logic [NUM_VOICES-1:0]       sync_q;
  logic [NUM_VOICES-1:0]       ring_q;
  logic [NUM_VOICES-1:0]       test_q;

  logic [ACCUMULATOR_BITS-1:0]   acc_next;
  logic [LFSR_BITS-1:0]          lfsr_next;
  logic                          msb_rise;
  logic signed [OUTPUT_BITS-1:0] voice_sample;
  logic signed [MIX_BITS-1:0]    sample_ext;

  // Modulation source is the previous voice, wrapping voice 0 onto the last one
  always_comb begin
    src_idx = (idx == '0) ? LAST_IDX : idx - VIDX_BITS'(1);
  end

  wave_voice_core #(
    .FREQ_BITS        (FREQ_BITS),
    .PULSEWIDTH_BITS  (PULSEWIDTH_BITS),
    .OUTPUT_BITS      (OUTPUT_BITS),
    .ACCUMULATOR_BITS (ACCUMULATOR_BITS)
  ) u_core (
    .acc       (acc_q[idx]),
    .lfsr      (lfsr_q[idx]),
    .freq      (freq_q[idx]),
    .pw        (pw_q[idx]),
    .wave      (wave_q[idx]),
    .sync      (sync_q[idx]),
    .ringmod   (ring_q[idx]),
    .test      (test_q[idx]),
    .src_msb   (acc_q[src_idx][MSB]),
    .src_rise  (rise_q[src_idx]),
    .acc_next  (acc_next),
    .lfsr_next (lfsr_next),
    .msb_rise  (msb_rise),
    .sample    (voice_sample)
  );

  assign sample_ext = {{(MIX_BITS-OUTPUT_BITS){voice_sample[OUTPUT_BITS-1]}}, voice_sample};

  // Expose each voice's phase MSB straight from its register
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_msb[i] = acc_q[i][MSB];
    end
  end

  // Sweep sequencer with registered mix/valid/busy outputs
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      mix_valid <= 1'b0;
      mix_acc   <= '0;
      mix_out   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          mix_valid <= 1'b0;
          if (sample_tick) begin
            state   <= ST_SWEEP;
            idx     <= '0;
            busy    <= 1'b1;
            mix_acc <= '0;
          end
        end
        ST_SWEEP: begin
          mix_acc <= mix_acc + sample_ext;
          if (idx == LAST_IDX) begin
            state     <= ST_DONE;
            idx       <= '0;
            mix_valid <= 1'b1;
            mix_out   <= mix_acc + sample_ext;
          end else begin
            idx <= idx + VIDX_BITS'(1);
          end
        end
        ST_DONE: begin
          mix_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          idx       <= '0;
          busy      <= 1'b0;
          mix_valid <= 1'b0;
        end
      endcase
    end
  end

  // Write back the voice being swept this cycle
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        acc_q[i]  <= '0;
        lfsr_q[i] <= LFSR_SEED;
      end
      rise_q <= '0;
    end else if (state == ST_SWEEP) begin
      acc_q[idx]  <= acc_next;
      lfsr_q[idx] <= lfsr_next;
      rise_q[idx] <= msb_rise;
    end
  end

  // Config register file; writes to nonexistent voices are dropped
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        freq_q[i] <= '0;
        pw_q[i]   <= '0;
        wave_q[i] <= '0;
      end
      sync_q <= '0;
      ring_q <= '0;
      test_q <= '0;
    end else if (cfg_we && ({1'b0, cfg_voice} < VOICE_LIMIT)) begin
      freq_q[cfg_voice] <= cfg_freq;
      pw_q[cfg_voice]   <= cfg_pw;
      wave_q[cfg_voice] <= cfg_wave;
      sync_q[cfg_voice] <= cfg_sync;
      ring_q[cfg_voice] <= cfg_ringmod;
      test_q[cfg_voice] <= cfg_test;
    end
  end

endmodule

// File: tb/tb_wave_poly.sv
// Directed bench for wave_poly: hand-computed mix values across waveforms, sync, ringmod, noise and control corners.
// Latency: expects mix_valid four cycles after a tick with three voices.
// Backpressure: exercises dropped ticks while busy and reset in mid-sweep.
module tb_wave_poly;

  localparam int NV = 3;
  localparam int FB = 24;
  localparam int PB = 12;
  localparam int OB = 12;
  localparam int AB = 24;
  localparam int VB = 2;
  localparam int MB = 15;

  logic                 main_clk;
  logic                 reset;
  logic                 sample_tick;
  logic                 cfg_we;
  logic [VB-1:0]        cfg_voice;
  logic [FB-1:0]        cfg_freq;
  logic [PB-1:0]        cfg_pw;
  logic [3:0]           cfg_wave;
  logic                 cfg_sync;
  logic                 cfg_ringmod;
  logic                 cfg_test;
  logic signed [MB-1:0] mix_out;
  logic                 mix_valid;
  logic                 busy;
  logic [NV-1:0]        voice_msb;

  int checks = 0;
  int errors = 0;
  logic signed [MB-1:0] v;
  int cnt;

  wave_poly #(
    .NUM_VOICES       (NV),
    .FREQ_BITS        (FB),
    .PULSEWIDTH_BITS  (PB),
    .OUTPUT_BITS      (OB),
    .ACCUMULATOR_BITS (AB)
  ) dut (
    .main_clk    (main_clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .cfg_we      (cfg_we),
    .cfg_voice   (cfg_voice),
    .cfg_freq    (cfg_freq),
    .cfg_pw      (cfg_pw),
    .cfg_wave    (cfg_wave),
    .cfg_sync    (cfg_sync),
    .cfg_ringmod (cfg_ringmod),
    .cfg_test    (cfg_test),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .busy        (busy),
    .voice_msb   (voice_msb)
  );

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge main_clk);
    reset = 1'b1;
    repeat (2) @(negedge main_clk);
    reset = 1'b0;
  endtask

  task automatic cfg(input int vc, input logic [FB-1:0] f, input logic [PB-1:0] p,
                     input logic [3:0] w, input logic s, input logic r, input logic t);
    @(negedge main_clk);
    cfg_we      = 1'b1;
    cfg_voice   = VB'(vc);
    cfg_freq    = f;
    cfg_pw      = p;
    cfg_wave    = w;
    cfg_sync    = s;
    cfg_ringmod = r;
    cfg_test    = t;
    @(negedge main_clk);
    cfg_we = 1'b0;
  endtask

  // One tick, bounded wait for mix_valid, latency checked, mix value returned
  task automatic do_tick(output logic signed [MB-1:0] val);
    int lat;
    @(negedge main_clk);
    sample_tick = 1'b1;
    @(negedge main_clk);
    sample_tick = 1'b0;
    lat = 1;
    while (mix_valid !== 1'b1 && lat < 20) begin
      @(negedge main_clk);
      lat++;
    end
    chk("latency", lat, 4);
    val = mix_out;
  endtask

  initial begin
    reset = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0; cfg_voice = '0; cfg_freq = '0;
    cfg_pw = '0; cfg_wave = '0; cfg_sync = 1'b0; cfg_ringmod = 1'b0; cfg_test = 1'b0;
    repeat (2) @(negedge main_clk);
    chk("rst_mix_out", mix_out, 0);
    chk("rst_mix_valid", mix_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_voice_msb", voice_msb, 0);
    reset = 1'b0;

    // Write to an out-of-range voice is ignored: mix stays silent
    cfg(3, 24'h001000, 12'h000, 4'b0010, 1'b0, 1'b0, 1'b0);
    do_tick(v);
    chk("bad_voice_ignored", v, 0);

    // Voice0 saw, step-by-step timing of busy/mix_valid
    cfg(0, 24'h001000, 12'h000, 4'b0010, 1'b0, 1'b0, 1'b0);
    @(negedge main_clk);
    sample_tick = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge main_clk);
      sample_tick = 1'b0;
      chk("busy_seq", busy, (c <= 4) ? 1 : 0);
      chk("valid_seq", mix_valid, (c == 4) ? 1 : 0);
      if (c == 4) chk("saw_mix", mix_out, -2047);
    end
    chk("saw_voice_msb", voice_msb, 0);

    // Pulse pw=0x800, freq=0x8000: high for 255 ticks, low on the 256th
    do_reset();
    cfg(0, 24'h008000, 12'h800, 4'b0100, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 256; k++) begin
      do_tick(v);
      if (k == 1 || k == 128 || k == 255) chk("pulse_hi", v, 2047);
      if (k == 256) chk("pulse_lo", v, -2048);
    end
    repeat (3) @(negedge main_clk);
    chk("mix_hold", mix_out, -2048);
    chk("valid_one_shot", mix_valid, 0);

    // Voice0 tri at half-scale step, voice1 tri ring-modulated by voice0
    do_reset();
    chk("rst_msb_cleared", voice_msb, 0);
    cfg(0, 24'h800000, 12'h000, 4'b0001, 1'b0, 1'b0, 1'b0);
    cfg(1, 24'h000000, 12'h000, 4'b0001, 1'b0, 1'b1, 1'b0);
    do_tick(v);
    chk("ring_mix1", v, 4094);
    chk("ring_msb1", voice_msb, 3'b001);
    do_tick(v);
    chk("ring_mix2", v, -4096);
    chk("ring_msb2", voice_msb, 3'b000);
    do_tick(v);
    chk("ring_mix3", v, 4094);
    chk("ring_msb3", voice_msb, 3'b001);

    // Hard sync: voice1 saw restarts whenever voice0 MSB rises
    do_reset();
    cfg(0, 24'h400000, 12'h000, 4'b0000, 1'b0, 1'b0, 1'b0);
    cfg(1, 24'h010000, 12'h000, 4'b0010, 1'b1, 1'b0, 1'b0);
    do_tick(v); chk("sync_t1", v, -2032);
    do_tick(v); chk("sync_t2", v, -2048);
    chk("sync_msb_t2", voice_msb, 3'b001);
    do_tick(v); chk("sync_t3", v, -2032);
    do_tick(v); chk("sync_t4", v, -2016);
    do_tick(v); chk("sync_t5", v, -2000);
    do_tick(v); chk("sync_t6", v, -2048);

    // Noise: test mode pins LFSR at seed, then top bits change on the 9th LFSR step
    do_reset();
    cfg(0, 24'h010000, 12'h000, 4'b1000, 1'b0, 1'b0, 1'b1);
    do_tick(v); chk("noise_test1", v, 2047);
    do_tick(v); chk("noise_test2", v, 2047);
    cfg(0, 24'h010000, 12'h000, 4'b1000, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 136; k++) begin
      do_tick(v);
      if (k == 1 || k == 8 || k == 135) chk("noise_seed", v, 2047);
      if (k == 136) chk("noise_step9", v, 2046);
    end

    // Second tick two cycles after the first is dropped
    do_reset();
    cfg(0, 24'h001000, 12'h000, 4'b0010, 1'b0, 1'b0, 1'b0);
    cnt = 0;
    @(negedge main_clk);
    sample_tick = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge main_clk);
      sample_tick = (c == 2);
      if (mix_valid === 1'b1) cnt++;
    end
    chk("single_valid", cnt, 1);
    chk("single_mix", mix_out, -2047);

    // Reset in mid-sweep: everything cleared at once, no mix_valid afterwards
    @(negedge main_clk);
    sample_tick = 1'b1;
    @(negedge main_clk);
    sample_tick = 1'b0;
    @(negedge main_clk);
    reset = 1'b1;
    #1;
    chk("midrst_mix_out", mix_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", mix_valid, 0);
    chk("midrst_msb", voice_msb, 0);
    @(negedge main_clk);
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge main_clk);
      if (mix_valid !== 1'b0) cnt++;
    end
    chk("midrst_no_valid", cnt, 0);
    do_tick(v);
    chk("midrst_cfg_cleared", v, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
